// File: rtl/huffman_stream_enc.sv
// Serial Huffman encoder: symbol in, run-time loadable code table, code bits out LSB-first.
// One symbol may load in the same cycle its predecessor's final bit leaves, so no bubble bits are inserted.
module huffman_stream_enc #(
  parameter int SYM_W   = 5,
  parameter int MAX_LEN = 9,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   sym,
  output logic               sym_ready,
  output logic               bit_valid,
  output logic               bit_out,
  output logic               bit_last,
  input  logic               bit_ready,
  output logic               err_sticky,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   sym_count
);

  localparam int DEPTH = 2**SYM_W;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] code_tbl [DEPTH];
  logic [LEN_W-1:0]   len_tbl  [DEPTH];
  logic [MAX_LEN-1:0] shift_q;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   wr_len;
  logic [LEN_W-1:0]   ent_len;
  logic [MAX_LEN-1:0] ent_code;
  logic               accept, beat, load, drop;

  // Over-long entries are clamped once here so the shifter never runs past MAX_LEN.
  assign wr_len   = (tbl_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tbl_len;
  assign ent_len  = len_tbl[sym];
  assign ent_code = code_tbl[sym];

  assign accept = sym_valid & sym_ready;
  assign beat   = bit_valid & bit_ready;
  assign load   = accept & (ent_len != '0);
  assign drop   = accept & (ent_len == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_tbl[i] <= '0;
        len_tbl[i]  <= '0;
      end
    end else if (tbl_we) begin
      code_tbl[tbl_addr] <= tbl_code;
      len_tbl[tbl_addr]  <= wr_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (beat && bit_last) state_nxt = load ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    bit_last  = 1'b0;
    sym_ready = 1'b1;
    case (state)
      IDLE: ;
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = shift_q[0];
        bit_last  = (remaining == LEN_W'(1));
        sym_ready = bit_last & bit_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      remaining <= '0;
    end else if (load) begin
      shift_q   <= ent_code;
      remaining <= ent_len;
    end else if (beat) begin
      shift_q   <= shift_q >> 1;
      remaining <= remaining - LEN_W'(1);
    end
  end

  // A drop in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_sticky <= 1'b0;
    else if (drop)    err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sym_count <= '0;
    else if (beat && bit_last) sym_count <= sym_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_huffman_stream_enc.sv
// Bench for huffman_stream_enc: table-driven vectors, directed corner sequences and a
// randomized run, all checked cycle by cycle against a queue-of-bits reference model.
module tb_huffman_stream_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [4:0]  tbl_addr = '0;
  logic [8:0]  tbl_code = '0;
  logic [3:0]  tbl_len = '0;
  logic        sym_valid = 1'b0;
  logic [4:0]  sym = '0;
  logic        sym_ready;
  logic        bit_valid, bit_out, bit_last;
  logic        bit_ready = 1'b0;
  logic        err_sticky;
  logic        err_clr = 1'b0;
  logic [15:0] sym_count;

  huffman_stream_enc #(.SYM_W(5), .MAX_LEN(9), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code),
    .tbl_len(tbl_len), .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
    .bit_valid(bit_valid), .bit_out(bit_out), .bit_last(bit_last), .bit_ready(bit_ready),
    .err_sticky(err_sticky), .err_clr(err_clr), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic last_acc;

  // Reference model: a table plus the queue of code bits still owed downstream.
  typedef struct { logic b; logic l; } mbit_t;
  logic [8:0] m_code [32];
  logic [3:0] m_len  [32];
  mbit_t      m_q[$];
  logic       m_err;
  logic [15:0] m_cnt;

  logic cap_b[$];
  logic cap_l[$];
  int   cap_c[$];

  typedef struct {
    logic [4:0] addr;
    logic [8:0] code;
    logic [3:0] len;
    logic [8:0] exp_bits;
    int         exp_n;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_code[i] = '0;
      m_len[i]  = '0;
    end
    m_q.delete();
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  task automatic cap_clear();
    cap_b.delete();
    cap_l.delete();
    cap_c.delete();
  endtask

  task automatic step(input logic we, input logic [4:0] addr, input logic [8:0] code,
                      input logic [3:0] len, input logic sv, input logic [4:0] s,
                      input logic br, input logic ec);
    logic e_valid, e_out, e_last, e_ready, newerr;
    @(negedge clk);
    tbl_we = we; tbl_addr = addr; tbl_code = code; tbl_len = len;
    sym_valid = sv; sym = s; bit_ready = br; err_clr = ec;
    #1;
    e_valid = (m_q.size() != 0);
    e_out   = e_valid ? m_q[0].b : 1'b0;
    e_last  = e_valid ? m_q[0].l : 1'b0;
    e_ready = !e_valid || (m_q.size() == 1 && br);
    chk("bit_valid", bit_valid, e_valid);
    chk("bit_out", bit_out, e_out);
    chk("bit_last", bit_last, e_last);
    chk("sym_ready", sym_ready, e_ready);
    chk("err_sticky", err_sticky, m_err);
    chk("sym_count", sym_count, m_cnt);
    if (bit_valid && br) begin
      cap_b.push_back(bit_out);
      cap_l.push_back(bit_last);
      cap_c.push_back(cyc);
    end
    last_acc = sv && e_ready;
    newerr = 1'b0;
    if (e_valid && br) begin
      if (m_q[0].l) m_cnt++;
      void'(m_q.pop_front());
    end
    if (last_acc) begin
      if (m_len[s] == 0) newerr = 1'b1;
      else for (int i = 0; i < int'(m_len[s]); i++)
        m_q.push_back('{b: m_code[s][i], l: (i == int'(m_len[s]) - 1)});
    end
    if (newerr) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    if (we) begin
      m_code[addr] = code;
      m_len[addr]  = (len > 4'd9) ? 4'd9 : len;
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic idle(input logic br);
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0, 5'd0, br, 1'b0);
  endtask

  task automatic write_ent(input logic [4:0] a, input logic [8:0] c, input logic [3:0] l);
    step(1'b1, a, c, l, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic send(input logic [4:0] s);
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1, s, 1'b1, 1'b0);
  endtask

  task automatic drain();
    repeat (11) idle(1'b1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    tbl_we = 0; sym_valid = 0; bit_ready = 0; err_clr = 0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_bit_valid"}, bit_valid, 1'b0);
    chk({tag, "_bit_out"}, bit_out, 1'b0);
    chk({tag, "_bit_last"}, bit_last, 1'b0);
    chk({tag, "_sym_ready"}, sym_ready, 1'b1);
    chk({tag, "_err"}, err_sticky, 1'b0);
    chk({tag, "_count"}, sym_count, 16'd0);
    model_reset();
    cap_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_cap(input string name, input logic [10:0] eb, input logic [10:0] el, input int n);
    chk({name, "_nbits"}, cap_b.size(), n);
    for (int i = 0; i < n && i < cap_b.size(); i++) begin
      chk($sformatf("%s_bit%0d", name, i), cap_b[i], eb[i]);
      chk($sformatf("%s_last%0d", name, i), cap_l[i], el[i]);
    end
  endtask

  initial begin
    int idx;
    int k;
    logic [4:0] b2b_syms [3];
    logic       stall_pat [4];

    // exp_bits[i] is the i-th transmitted bit
    vecs[0] = '{addr: 5'd4,  code: 9'b010,  len: 4'd3,  exp_bits: 9'b010,  exp_n: 3};
    vecs[1] = '{addr: 5'd0,  code: 9'h001,  len: 4'd1,  exp_bits: 9'h001,  exp_n: 1};
    vecs[2] = '{addr: 5'd1,  code: 9'h1AB,  len: 4'd9,  exp_bits: 9'h1AB,  exp_n: 9};
    vecs[3] = '{addr: 5'd5,  code: 9'h0B5,  len: 4'd8,  exp_bits: 9'h0B5,  exp_n: 8};
    vecs[4] = '{addr: 5'd2,  code: 9'h155,  len: 4'd15, exp_bits: 9'h155,  exp_n: 9};
    vecs[5] = '{addr: 5'd9,  code: 9'h1FF,  len: 4'd2,  exp_bits: 9'h003,  exp_n: 2};
    vecs[6] = '{addr: 5'd31, code: 9'h100,  len: 4'd10, exp_bits: 9'h100,  exp_n: 9};

    do_reset("reset");

    for (int v = 0; v < 7; v++) begin
      write_ent(vecs[v].addr, vecs[v].code, vecs[v].len);
      cap_clear();
      send(vecs[v].addr);
      drain();
      chk_cap($sformatf("vec%0d", v), {2'b00, vecs[v].exp_bits},
              11'(1) << (vecs[v].exp_n - 1), vecs[v].exp_n);
      #1 chk($sformatf("vec%0d_count", v), sym_count, 16'(v + 1));
    end

    // Back-to-back codes with no bubble
    do_reset("rst_b2b");
    write_ent(5'd0, 9'h001, 4'd1);
    write_ent(5'd1, 9'h1AB, 4'd9);
    b2b_syms[0] = 5'd0; b2b_syms[1] = 5'd1; b2b_syms[2] = 5'd0;
    idx = 0; k = 0;
    while (idx < 3 && k < 30) begin
      send(b2b_syms[idx]);
      if (last_acc) idx++;
      k++;
    end
    chk("b2b_accepted", idx, 3);
    drain();
    chk_cap("b2b", {1'b1, 9'h1AB, 1'b1}, 11'b110_0000_0001, 11);
    if (cap_c.size() == 11) chk("b2b_span", cap_c[10] - cap_c[0], 10);
    else chk("b2b_span_nbits", cap_c.size(), 11);
    #1 chk("b2b_count", sym_count, 16'd3);

    // Backpressure pattern 1,0,0,1
    do_reset("rst_stall");
    write_ent(5'd5, 9'h0B5, 4'd8);
    send(5'd5);
    stall_pat[0] = 1; stall_pat[1] = 0; stall_pat[2] = 0; stall_pat[3] = 1;
    k = 0;
    while (cap_b.size() < 8 && k < 60) begin
      idle(stall_pat[k % 4]);
      k++;
    end
    drain();
    chk_cap("stall", 11'h0B5, 11'h080, 8);

    // Invalid symbol and err_clr priority
    do_reset("rst_err");
    send(5'd7);
    #1 chk("err_set", err_sticky, 1'b1);
    chk("err_no_valid", bit_valid, 1'b0);
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1, 5'd7, 1'b1, 1'b1);
    #1 chk("err_clr_vs_new", err_sticky, 1'b1);
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    #1 chk("err_cleared", err_sticky, 1'b0);

    // Write/accept collision, then clamp
    do_reset("rst_coll");
    write_ent(5'd2, 9'b101, 4'd3);
    cap_clear();
    step(1'b1, 5'd2, 9'b0110, 4'd4, 1'b1, 5'd2, 1'b1, 1'b0);
    drain();
    chk_cap("coll_old", 11'b101, 11'b100, 3);
    cap_clear();
    send(5'd2);
    drain();
    chk_cap("coll_new", 11'b0110, 11'b1000, 4);
    write_ent(5'd2, 9'h155, 4'd15);
    cap_clear();
    send(5'd2);
    drain();
    chk_cap("clamp", 11'h155, 11'h100, 9);

    // Reset in the middle of a code
    do_reset("rst_mid0");
    write_ent(5'd4, 9'h1FF, 4'd9);
    send(5'd4);
    idle(1'b1);
    idle(1'b1);
    do_reset("rst_mid");
    send(5'd4);
    #1 chk("mid_err_after", err_sticky, 1'b1);
    chk("mid_no_valid", bit_valid, 1'b0);
    idle(1'b1);

    // Randomized traffic
    do_reset("rst_rand");
    for (int i = 0; i < 8; i++)
      write_ent(5'(i), 9'($urandom), 4'($urandom_range(1, 15)));
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) == 0), 5'($urandom_range(0, 9)), 9'($urandom),
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 9)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
